ofs_csr_scratch_rsp: RTL and testbench

OFS_CSR_SCRATCH_RSP -- requirements
Module: ofs_csr_scratch_rsp

---
 rtl/ofs_csr_scratch_rsp.sv | 180 ++++++++++++++++++
 tb/tb_ofs_csr_scratch_rsp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_csr_scratch_rsp.sv
// CSR block with DFH/GUID read-only words, SCRATCHPAD and TESTPAD registers, and a one-deep
// read response buffer. Optional macro CSR_RSP_ERR_EN adds ERR_CNT at 0x20 and rsp_err reporting.
module ofs_csr_scratch_rsp #(
  parameter logic [63:0] DFH_VALUE     = 64'h3000_0000_1000_0010,
  parameter logic [63:0] GUID_L_VALUE  = 64'h0,
  parameter logic [63:0] GUID_H_VALUE  = 64'h0,
  parameter logic [63:0] TESTPAD_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_be,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [15:0] rd_addr,
  input  logic [9:0]  rd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [9:0]  rsp_tag,
  output logic        rsp_err,
  output logic        dbg_rsp_state_o
);

  localparam logic [15:0] ADDR_DFH     = 16'h0000;
  localparam logic [15:0] ADDR_GUID_L  = 16'h0008;
  localparam logic [15:0] ADDR_GUID_H  = 16'h0010;
  localparam logic [15:0] ADDR_SCRATCH = 16'h0018;
  localparam logic [15:0] ADDR_ERR_CNT = 16'h0020;
  localparam logic [15:0] ADDR_TESTPAD = 16'h0038;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Handshakes: a transfer happens on a cycle where valid && ready are both 1 at the clk edge.
  // Writes are always ready; reads are ready whenever the response slot is free or draining.

  logic [0:0]  state_q, state_d;
  logic [63:0] scratch_q, scratch_d;
  logic [63:0] testpad_q, testpad_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [9:0]  rsp_tag_q, rsp_tag_d;

  logic        wr_aligned;
  logic        rd_aligned;
  logic        rd_accept;
  logic        rd_mapped;
  logic [63:0] rd_value;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign wr_ready   = 1'b1;
  assign wr_aligned = (wr_addr[2:0] == 3'b000);
  assign rd_aligned = (rd_addr[2:0] == 3'b000);

  assign rsp_valid       = (state_q == ST_FULL);
  assign rd_ready        = !rsp_valid || rsp_ready;
  assign rd_accept       = rd_valid && rd_ready;
  assign rsp_data        = rsp_data_q;
  assign rsp_tag         = rsp_tag_q;
  assign dbg_rsp_state_o = state_q;

`ifdef CSR_RSP_ERR_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        rsp_err_q, rsp_err_d;
  logic        wr_mapped;
`endif

  // Read decode uses the current register contents, so a same-cycle write is not visible.
  always_comb begin
    rd_value  = 64'h0;
    rd_mapped = 1'b0;
    if (rd_aligned) begin
      rd_mapped = 1'b1;
      case (rd_addr)
        ADDR_DFH:     rd_value = DFH_VALUE;
        ADDR_GUID_L:  rd_value = GUID_L_VALUE;
        ADDR_GUID_H:  rd_value = GUID_H_VALUE;
        ADDR_SCRATCH: rd_value = scratch_q;
        ADDR_TESTPAD: rd_value = testpad_q;
`ifdef CSR_RSP_ERR_EN
        ADDR_ERR_CNT: rd_value = {48'h0, err_cnt_q};
`endif
        default:      rd_mapped = 1'b0;
      endcase
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    testpad_d = testpad_q;
    if (wr_valid && wr_aligned) begin
      if (wr_addr == ADDR_SCRATCH) scratch_d = merge_bytes(scratch_q, wr_data, wr_be);
      if (wr_addr == ADDR_TESTPAD) testpad_d = merge_bytes(testpad_q, wr_data, wr_be);
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    case (state_q)
      ST_EMPTY: if (rd_accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !rd_accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (rd_accept) begin
      rsp_data_d = rd_mapped ? rd_value : 64'h0;
      rsp_tag_d  = rd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      scratch_q  <= 64'h0;
      testpad_q  <= TESTPAD_RESET;
      rsp_data_q <= 64'h0;
      rsp_tag_q  <= 10'h0;
    end else begin
      state_q    <= state_d;
      scratch_q  <= scratch_d;
      testpad_q  <= testpad_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

`ifdef CSR_RSP_ERR_EN
  logic        err_clr;
  logic [15:0] err_base;
  logic [16:0] err_sum;

  always_comb begin
    wr_mapped = 1'b0;
    if (wr_aligned) begin
      case (wr_addr)
        ADDR_DFH, ADDR_GUID_L, ADDR_GUID_H,
        ADDR_SCRATCH, ADDR_ERR_CNT, ADDR_TESTPAD: wr_mapped = 1'b1;
        default:                                  wr_mapped = 1'b0;
      endcase
    end
  end

  // A clear and an error in the same cycle: the clear applies first, then the errors count.
  assign err_clr  = wr_valid && wr_aligned && (wr_addr == ADDR_ERR_CNT);
  assign err_base = err_clr ? 16'h0 : err_cnt_q;
  assign err_sum  = {1'b0, err_base}
                  + {16'h0, (rd_accept && !rd_mapped)}
                  + {16'h0, (wr_valid && !wr_mapped)};
  assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign rsp_err_d = rd_accept ? !rd_mapped : rsp_err_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 16'h0;
      rsp_err_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ofs_csr_scratch_rsp.sv
// Randomized bench for ofs_csr_scratch_rsp against a register-map reference model with an
// expected-response queue; directed sequences cover the reset, hold-off and ordering cases.
module tb_ofs_csr_scratch_rsp;

  localparam logic [63:0] DFH_V    = 64'h3000_0000_1000_0010;
  localparam logic [63:0] GUID_L_V = 64'h1122_3344_5566_7788;
  localparam logic [63:0] GUID_H_V = 64'h99AA_BBCC_DDEE_F001;
  localparam logic [63:0] TP_RST   = 64'hA5A5_0000_1234_5678;
`ifdef CSR_RSP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_addr;
  logic [9:0]  rd_tag;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [9:0]  rsp_tag;
  logic        rsp_err;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  ofs_csr_scratch_rsp #(
    .DFH_VALUE(DFH_V), .GUID_L_VALUE(GUID_L_V), .GUID_H_VALUE(GUID_H_V), .TESTPAD_RESET(TP_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .dbg_rsp_state_o(dbg_state)
  );

  // reference model: register contents and the queue of responses not yet taken
  logic [63:0] m_scratch, m_testpad;
  int          m_err_cnt;
  logic [63:0] exp_q[$];
  logic [9:0]  exp_tag_q[$];
  logic        exp_err_q[$];
  bit          m_init = 1'b0;
  bit          m_just_reset = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_mapped(input logic [15:0] a);
    if (a % 8 != 0) return 1'b0;
    if (a == 16'h00 || a == 16'h08 || a == 16'h10 || a == 16'h18 || a == 16'h38) return 1'b1;
    return ERR_EN && (a == 16'h20);
  endfunction

  function automatic logic [63:0] model_read(input logic [15:0] a);
    if (!is_mapped(a)) return 64'h0;
    case (a)
      16'h00:  return DFH_V;
      16'h08:  return GUID_L_V;
      16'h10:  return GUID_H_V;
      16'h18:  return m_scratch;
      16'h38:  return m_testpad;
      16'h20:  return 64'(m_err_cnt);
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] apply_be(input logic [63:0] old_v, input logic [63:0] new_v,
                                           input logic [7:0] be);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

  task automatic check_outputs();
    check_eq("wr_ready", 64'(wr_ready), 64'h1);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
    check_eq("rd_ready", 64'(rd_ready), 64'((exp_q.size() == 0) || rsp_ready));
    if (exp_q.size() != 0) begin
      check_eq("rsp_data", rsp_data, exp_q[0]);
      check_eq("rsp_tag", 64'(rsp_tag), 64'(exp_tag_q[0]));
      check_eq("rsp_err", 64'(rsp_err), 64'(exp_err_q[0]));
    end else if (m_just_reset) begin
      check_eq("rst_data", rsp_data, 64'h0);
      check_eq("rst_tag", 64'(rsp_tag), 64'h0);
      check_eq("rst_err", 64'(rsp_err), 64'h0);
    end
  endtask

  task automatic predict();
    bit take, acc, clr;
    int inc;
    if (!rst_n) begin
      exp_q.delete(); exp_tag_q.delete(); exp_err_q.delete();
      m_scratch = 64'h0; m_testpad = TP_RST; m_err_cnt = 0;
      m_init = 1'b1; m_just_reset = 1'b1;
      return;
    end
    take = (exp_q.size() != 0) && rsp_ready;
    acc  = rd_valid && ((exp_q.size() == 0) || rsp_ready);
    if (take) begin
      void'(exp_q.pop_front()); void'(exp_tag_q.pop_front()); void'(exp_err_q.pop_front());
    end
    inc = 0;
    if (acc) begin
      exp_q.push_back(model_read(rd_addr));
      exp_tag_q.push_back(rd_tag);
      exp_err_q.push_back(ERR_EN && !is_mapped(rd_addr));
      m_just_reset = 1'b0;
      if (!is_mapped(rd_addr)) inc++;
    end
    clr = 1'b0;
    if (wr_valid) begin
      if (!is_mapped(wr_addr)) inc++;
      else if (wr_addr == 16'h18) m_scratch = apply_be(m_scratch, wr_data, wr_be);
      else if (wr_addr == 16'h38) m_testpad = apply_be(m_testpad, wr_data, wr_be);
      else if (wr_addr == 16'h20) clr = 1'b1;
    end
    if (ERR_EN) begin
      if (clr) m_err_cnt = 0;
      m_err_cnt = (m_err_cnt + inc > 65535) ? 65535 : m_err_cnt + inc;
    end
  endtask

  // driver: inputs are already set; check current outputs, predict the edge, move to next negedge
  task automatic tick();
    #1;
    if (m_init) check_outputs();
    predict();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    rd_valid = 0; rd_addr = 0; rd_tag = 0; rsp_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic set_rd(input logic [15:0] a, input logic [9:0] t);
    rd_valid = 1; rd_addr = a; rd_tag = t;
  endtask

  task automatic set_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_valid = 1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] a;
    case ($urandom_range(0, 9))
      0: a = 16'h00;
      1: a = 16'h08;
      2: a = 16'h10;
      3, 4: a = 16'h18;
      5: a = 16'h20;
      6, 7: a = 16'h38;
      8: a = 16'h40;
      default: a = 16'($urandom_range(0, 16'hFFFF));
    endcase
    if ($urandom_range(0, 7) == 0) a = a | 16'($urandom_range(1, 7));
    return a;
  endfunction

  initial begin
    idle_inputs();
    rst_n = 0;
    do_reset();

    // DFH read with tag 0x3A, response one cycle later
    set_rd(16'h00, 10'h3A); tick(); idle_inputs(); #1;
    check_eq("dfh_data", rsp_data, DFH_V);
    check_eq("dfh_tag", 64'(rsp_tag), 64'h3A);
    tick();

    // partial byte-enable write then read
    set_wr(16'h18, 64'hDEAD_BEEF_0123_4567, 8'h0F); tick(); idle_inputs();
    set_rd(16'h18, 10'h11); rsp_ready = 0; tick();
    // hold-off: response stays while rsp_ready is low, new read waits
    set_rd(16'h38, 10'h12); rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("hold_rd_ready", 64'(rd_ready), 64'h0);
      check_eq("hold_data", rsp_data, 64'h0000_0000_0123_4567);
      tick();
    end
    rsp_ready = 1; #1;
    check_eq("release_rd_ready", 64'(rd_ready), 64'h1);
    tick(); idle_inputs(); #1;
    check_eq("b2b_data", rsp_data, TP_RST);
    check_eq("b2b_tag", 64'(rsp_tag), 64'h12);
    tick();

    // same-cycle write and read of TESTPAD returns the pre-write value
    do_reset();
    set_wr(16'h38, 64'h55, 8'hFF); set_rd(16'h38, 10'h21); tick(); idle_inputs(); #1;
    check_eq("raw_old", rsp_data, TP_RST);
    set_rd(16'h38, 10'h22); tick(); idle_inputs(); #1;
    check_eq("raw_new", rsp_data, 64'h55);
    tick();

`ifdef CSR_RSP_ERR_EN
    do_reset();
    set_rd(16'h40, 10'h31); tick(); #1;
    check_eq("unm_data", rsp_data, 64'h0);
    check_eq("unm_err", 64'(rsp_err), 64'h1);
    set_rd(16'h1C, 10'h32); tick(); #1;
    check_eq("mis_data", rsp_data, 64'h0);
    check_eq("mis_err", 64'(rsp_err), 64'h1);
    set_rd(16'h20, 10'h33); tick(); idle_inputs(); #1;
    check_eq("errcnt", rsp_data, 64'h2);
    tick();
`endif

    // reset while a response is stalled discards it and clears SCRATCHPAD
    set_wr(16'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); tick(); idle_inputs();
    set_rd(16'h18, 10'h3F); rsp_ready = 0; tick(); idle_inputs(); rsp_ready = 0;
    rst_n = 0; tick(); rst_n = 1; rsp_ready = 0; #1;
    check_eq("rst_valid", 64'(rsp_valid), 64'h0);
    check_eq("rst_rd_ready", 64'(rd_ready), 64'h1);
    tick();
    set_rd(16'h18, 10'h05); rsp_ready = 1; tick(); idle_inputs(); #1;
    check_eq("rst_scratch", rsp_data, 64'h0);
    tick();

    // randomized traffic with rare resets
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      wr_valid  = ($urandom_range(0, 9) < 3);
      wr_addr   = pick_addr();
      wr_data   = {$urandom, $urandom};
      wr_be     = 8'($urandom_range(0, 255));
      rd_valid  = ($urandom_range(0, 9) < 6);
      rd_addr   = pick_addr();
      rd_tag    = 10'($urandom_range(0, 1023));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1; idle_inputs(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
